// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode queue: default geometry,
// the NOP encoding shown to decode when the queue is empty, and the entry layout.
package fetch_queue_pkg;

  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_INST_W = 32;
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_CNT_W  = 16;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // One buffered fetch result at the default widths.
  typedef struct packed {
    logic [DEFAULT_INST_W-1:0] inst;
    logic [DEFAULT_ADDR_W-1:0] next_addr;
  } fetch_entry_t;

  // Storage width of one entry for arbitrary instruction/address widths.
  function automatic int entry_w(input int inst_w, input int addr_w);
    return inst_w + addr_w;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle. The master drives fetch results and
// decode/branch controls; the slave (the queue) returns PCWrite and the head entry.
interface fetch_queue_if #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
);

  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic [ADDR_W-1:0] in_next_addr;
  logic              pc_write;
  logic              flush;
  logic              id_stall;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_next_addr;

  modport master (
    output in_valid, in_inst, in_next_addr, flush, id_stall,
    input  pc_write, out_valid, out_inst, out_next_addr
  );

  modport slave (
    input  in_valid, in_inst, in_next_addr, flush, id_stall,
    output pc_write, out_valid, out_inst, out_next_addr
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// Entry array for fetch_queue: one synchronous write port and one
// asynchronous read port so the head entry is visible in the cycle after its write.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and
  // count, so stale contents are never observable and no reset fan-out is needed.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO between fetch and decode: buffers {inst, PC+4} pairs,
// drives fetch back-pressure via PCWrite and discards wrong-path entries on flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int INST_W = DEFAULT_INST_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = DEFAULT_CNT_W,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.slave     bus,
  output logic [OCC_W-1:0] count,
  output logic [CNT_W-1:0] full_stall_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(INST_W, ADDR_W);

  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               head_valid;
  logic               pop;
  logic               push;
  logic               pc_write_int;
  logic               stall_cycle;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Handshake terms. id_stall reaches pc_write combinationally on purpose:
  // a full queue frees a slot in the same cycle decode consumes the head.
  assign head_valid   = (count != '0);
  assign pop          = head_valid && !bus.id_stall && !bus.flush;
  assign pc_write_int = bus.flush || (count < FULL_COUNT) || pop;
  assign push         = bus.in_valid && pc_write_int && !bus.flush;
  assign stall_cycle  = bus.in_valid && !pc_write_int;
  assign wr_entry     = {bus.in_inst, bus.in_next_addr};

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so plain increment wraps the pointers.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Only a reset clears the counter; flushes leave the statistic intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_stall_cnt <= '0;
    end else if (stall_cycle && (full_stall_cnt != CNT_MAX)) begin
      full_stall_cnt <= full_stall_cnt + CNT_W'(1);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    bus.out_valid     = 1'b0;
    bus.out_inst      = INST_W'(NOP_INST);
    bus.out_next_addr = '0;
    if (head_valid) begin
      bus.out_valid     = 1'b1;
      bus.out_inst      = rd_entry[ENTRY_W-1 -: INST_W];
      bus.out_next_addr = rd_entry[ADDR_W-1:0];
    end
  end

  assign bus.pc_write = pc_write_int;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count <= FULL_COUNT);

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
    !(pop && (count == '0)));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count == FULL_COUNT)));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage.
- Captures each fetched {instruction, PC+4} pair into a small circular FIFO and presents the oldest entry to decode.
- Generates the fetch stage's PC-write enable for back-pressure.
- Discards all buffered wrong-path instructions on a taken branch or jump (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- INST_W, 32, instruction width
- ADDR_W, 32, PC+4 address width
- CNT_W, 16, width of the saturating full-stall performance counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- in_valid  input  1  fetch stage has a valid instruction this cycle
- in_inst  input  INST_W  fetched instruction
- in_next_addr  input  ADDR_W  PC+4 of the fetched instruction
- pc_write  output  1  drives the fetch stage's PCWrite
- flush  input  1  taken branch or jump resolved; discard the queue
- id_stall  input  1  decode cannot consume this cycle
- out_valid  output  1  head entry valid
- out_inst  output  INST_W  head instruction; NOP when empty
- out_next_addr  output  ADDR_W  head PC+4; 0 when empty
- count  output  $clog2(DEPTH+1)  current occupancy
- full_stall_cnt  output  CNT_W  cycles with in_valid=1 and pc_write=0; saturating

Behaviour:
- State: storage[DEPTH], wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count, full_stall_cnt.
- Reset (rst=0, asynchronous, takes effect immediately):
  - pointers, count and full_stall_cnt go to 0.
  - out_valid=0, out_inst=NOP (32'h0), out_next_addr=0, pc_write=1.
  - Storage contents need not be cleared.
  - A reset asserted mid-operation discards all entries.
- Combinational terms:
  - pop = out_valid & ~id_stall & ~flush
  - pc_write = flush | (count < DEPTH) | pop. The id_stall -> pc_write path is intentionally combinational.
  - push = in_valid & pc_write & ~flush
- Outputs:
  - out_valid = (count != 0).
  - out_inst and out_next_addr come from storage[rd_ptr] when valid; NOP and 0 when empty.
- Latency and ordering:
  - An entry pushed in cycle N is first visible on out_* in cycle N+1.
  - There is no same-cycle bypass, so pop never occurs when empty.
  - Strict FIFO order is preserved across pointer wrap.
- Clock-edge updates:
  - push only: write storage[wr_ptr], wr_ptr++, count++.
  - pop only: rd_ptr++, count--.
  - push & pop (any occupancy, including full): write, both pointers advance, count unchanged.
  - flush (dominates all): wr_ptr=rd_ptr=0, count=0. The current in_inst is dropped; no pop is counted. pc_write=1 during the flush cycle, so the fetch stage loads the branch/jump target. out_valid=0 from the next cycle.
- Full: with count==DEPTH and no pop, pc_write=0. The fetch stage holds its PC, and in_* must be held stable by the fetch stage.
- full_stall_cnt:
  - Increments each cycle with in_valid & ~pc_write.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.

Decomposition:
- Shared package: NOP_INST constant (32'h0), fetch-entry struct/width {inst, next_addr} = INST_W+ADDR_W, default DEPTH.
- One sub-module, fq_storage: DEPTH x (INST_W+ADDR_W) register array with a synchronous write port and an asynchronous read port. Pointer, count and counter logic stay in fetch_queue.

Test Plan:
1. Two pushes, then rst=0 mid-cycle -> immediately count=0, out_valid=0, out_inst=0, pc_write=1, full_stall_cnt=0, without waiting for a clock edge.
2. in_valid=1, in_inst=32'h20080005, in_next_addr=32'h4, id_stall=1 for one cycle -> next cycle out_valid=1, out_inst=32'h20080005, out_next_addr=32'h4, count=1.
3. DEPTH=4, id_stall=1, four pushes:
   - after the pushes: count=4, pc_write=0.
   - in_valid held 3 more cycles: full_stall_cnt=3.
   - then id_stall=0: pc_write=1 that same cycle, push+pop occurs, count stays 4.
4. count=3 and in_valid=1, assert flush one cycle -> pc_write=1 in the flush cycle; next cycle count=0, out_valid=0; the flushed-cycle instruction never appears on out_inst.
5. Stream instructions 0..9 with id_stall toggling 1,0,0,1,... -> out_inst sequence is exactly 0..9 in order across pointer wrap, with no duplicates or drops.
6. Hold the queue full with in_valid=1 for 70000 cycles (CNT_W=16) -> full_stall_cnt=16'hFFFF and stays there.
